// File: rtl/display_cmd_receiver_pkg.sv
// Shared display command header: ILI9341 command codes, DC encoding, pixel formats
// and the decoder's state types.
package display_cmd_receiver_pkg;

    localparam logic COMMAND_BIT = 1'b0;
    localparam logic DATA_BIT    = 1'b1;

    localparam logic [7:0] CMD_SW_RESET   = 8'h01;
    localparam logic [7:0] CMD_SLEEP_OUT  = 8'h11;
    localparam logic [7:0] CMD_DISPLAY_ON = 8'h29;
    localparam logic [7:0] CMD_CASET      = 8'h2A;
    localparam logic [7:0] CMD_PASET      = 8'h2B;
    localparam logic [7:0] CMD_RAMWR      = 8'h2C;
    localparam logic [7:0] CMD_MADCTL     = 8'h36;
    localparam logic [7:0] CMD_PIXFMT     = 8'h3A;

    localparam logic [7:0] RGB565 = 8'h55;
    localparam logic [7:0] RGB666 = 8'h66;

    typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_RAMWR, ST_DISCARD} state_t;
    typedef enum logic [1:0] {P_PIXFMT, P_MADCTL, P_CASET, P_PASET} param_t;

endpackage

// File: rtl/display_cmd_receiver_if.sv
// Panel-side SPI pins plus the decoded pixel-write and status outputs.
interface display_cmd_receiver_if;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        dc;
    logic        dis_reset;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_data;
    logic        sleeping;
    logic        display_on;
    logic [7:0]  pix_fmt;
    logic [7:0]  madctl;
    logic        cmd_unknown;
    logic        window_err;

    modport master (
        output spi_sck, spi_mosi, spi_cs_n, dc, dis_reset,
        input  pix_valid, pix_x, pix_y, pix_data, sleeping, display_on,
               pix_fmt, madctl, cmd_unknown, window_err
    );
    modport slave (
        input  spi_sck, spi_mosi, spi_cs_n, dc, dis_reset,
        output pix_valid, pix_x, pix_y, pix_data, sleeping, display_on,
               pix_fmt, madctl, cmd_unknown, window_err
    );
endinterface

// File: rtl/display_cmd_receiver_spi_byte_receiver.sv
// SPI mode-0 byte deserialiser: synchronises the panel pins into clk and
// assembles MSB-first bytes, tagging each with the DC level at its 8th bit.
module spi_byte_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sck,
    input  logic       i_mosi,
    input  logic       i_cs_n,
    input  logic       i_dc,
    input  logic       i_dis_reset_n,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_dc,
    output logic       o_dis_reset
);
    // Stage layout {dis_reset_n, dc, cs_n, mosi, sck}; idle = deselected, not in reset.
    localparam logic [4:0] SYNC_IDLE = 5'b10100;

    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic       r_sck_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_rx_valid;
    logic [7:0] r_rx_byte;
    logic       r_rx_dc;

    logic w_sck, w_mosi, w_cs_n, w_dc, w_dis_reset_n, w_sck_rise;

    assign {w_dis_reset_n, w_dc, w_cs_n, w_mosi, w_sck} = r_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= {SYNC_STAGES{SYNC_IDLE}};
            r_sck_prev <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= 8'd0;
            r_rx_dc    <= 1'b0;
        end else begin
            r_sync[0] <= {i_dis_reset_n, i_dc, i_cs_n, i_mosi, i_sck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sck_prev <= w_sck;
            r_rx_valid <= 1'b0;
            // Deselect or panel reset throws away any partially shifted byte.
            if (w_cs_n || !w_dis_reset_n) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_valid <= 1'b1;
                    r_rx_byte  <= {r_shift, w_mosi};
                    r_rx_dc    <= w_dc;
                end
            end
        end
    end

    assign o_rx_valid  = r_rx_valid;
    assign o_rx_byte   = r_rx_byte;
    assign o_rx_dc     = r_rx_dc;
    assign o_dis_reset = ~w_dis_reset_n;

endmodule

// File: rtl/display_cmd_receiver.sv
// Panel end of the ILI9341-style link: decodes command/parameter bytes and turns
// RAMWR payload into addressed RGB565 pixel writes.
module display_cmd_receiver
    import display_cmd_receiver_pkg::*;
#(
    parameter int DIS_RES_X   = 240,
    parameter int DIS_RES_Y   = 320,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   reset,
    display_cmd_receiver_if.slave bus
);
    localparam logic [15:0] X_MAX = 16'(DIS_RES_X - 1);
    localparam logic [15:0] Y_MAX = 16'(DIS_RES_Y - 1);

    logic       w_rx_valid, w_rx_dc, w_dis_reset;
    logic [7:0] w_rx_byte;

    spi_byte_receiver #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk(clk), .reset(reset),
        .i_sck(bus.spi_sck), .i_mosi(bus.spi_mosi), .i_cs_n(bus.spi_cs_n),
        .i_dc(bus.dc), .i_dis_reset_n(bus.dis_reset),
        .o_rx_valid(w_rx_valid), .o_rx_byte(w_rx_byte), .o_rx_dc(w_rx_dc),
        .o_dis_reset(w_dis_reset)
    );

    state_t      r_state, w_state_next;
    param_t      r_param, w_param_next;
    logic [1:0]  r_param_cnt, w_param_cnt_next;
    logic [23:0] r_param_buf, w_param_buf_next;
    logic [7:0]  r_hi, w_hi_next;
    logic        r_hi_valid, w_hi_valid_next;
    logic [15:0] r_cur_x, w_cur_x_next, r_cur_y, w_cur_y_next;
    logic [15:0] r_col_start, w_col_start_next, r_col_end, w_col_end_next;
    logic [15:0] r_page_start, w_page_start_next, r_page_end, w_page_end_next;
    logic        r_sleeping, w_sleeping_next, r_display_on, w_display_on_next;
    logic [7:0]  r_pix_fmt, w_pix_fmt_next, r_madctl, w_madctl_next;
    logic        r_pix_valid, w_pix_valid_next;
    logic [15:0] r_pix_x, w_pix_x_next, r_pix_y, w_pix_y_next, r_pix_data, w_pix_data_next;
    logic        r_cmd_unknown, w_cmd_unknown_next, r_window_err, w_window_err_next;

    logic        w_sw_reset;
    logic [15:0] w_win_start, w_win_end, w_win_max;

    assign w_sw_reset  = w_rx_valid && (w_rx_dc == COMMAND_BIT) && (w_rx_byte == CMD_SW_RESET);
    assign w_win_start = r_param_buf[23:8];
    assign w_win_end   = {r_param_buf[7:0], w_rx_byte};
    assign w_win_max   = (r_param == P_CASET) ? X_MAX : Y_MAX;

    always_comb begin
        w_state_next       = r_state;
        w_param_next       = r_param;
        w_param_cnt_next   = r_param_cnt;
        w_param_buf_next   = r_param_buf;
        w_hi_next          = r_hi;
        w_hi_valid_next    = r_hi_valid;
        w_cur_x_next       = r_cur_x;
        w_cur_y_next       = r_cur_y;
        w_col_start_next   = r_col_start;
        w_col_end_next     = r_col_end;
        w_page_start_next  = r_page_start;
        w_page_end_next    = r_page_end;
        w_sleeping_next    = r_sleeping;
        w_display_on_next  = r_display_on;
        w_pix_fmt_next     = r_pix_fmt;
        w_madctl_next      = r_madctl;
        w_pix_valid_next   = 1'b0;
        w_pix_x_next       = r_pix_x;
        w_pix_y_next       = r_pix_y;
        w_pix_data_next    = r_pix_data;
        w_cmd_unknown_next = 1'b0;
        w_window_err_next  = 1'b0;

        // Panel reset outranks a byte completing in the same cycle.
        if (w_dis_reset || w_sw_reset) begin
            w_state_next      = ST_IDLE;
            w_param_cnt_next  = 2'd0;
            w_hi_valid_next   = 1'b0;
            w_sleeping_next   = 1'b1;
            w_display_on_next = 1'b0;
            w_pix_fmt_next    = RGB666;
            w_madctl_next     = 8'h00;
            w_col_start_next  = 16'd0;
            w_col_end_next    = X_MAX;
            w_page_start_next = 16'd0;
            w_page_end_next   = Y_MAX;
        end else if (w_rx_valid && w_rx_dc == COMMAND_BIT) begin
            w_param_cnt_next = 2'd0;
            w_hi_valid_next  = 1'b0;
            unique case (w_rx_byte)
                CMD_SLEEP_OUT:  begin w_sleeping_next = 1'b0;   w_state_next = ST_IDLE; end
                CMD_DISPLAY_ON: begin w_display_on_next = 1'b1; w_state_next = ST_IDLE; end
                CMD_PIXFMT:     begin w_param_next = P_PIXFMT;  w_state_next = ST_PARAM; end
                CMD_MADCTL:     begin w_param_next = P_MADCTL;  w_state_next = ST_PARAM; end
                CMD_CASET:      begin w_param_next = P_CASET;   w_state_next = ST_PARAM; end
                CMD_PASET:      begin w_param_next = P_PASET;   w_state_next = ST_PARAM; end
                CMD_RAMWR: begin
                    w_cur_x_next = r_col_start;
                    w_cur_y_next = r_page_start;
                    w_state_next = ST_RAMWR;
                end
                default: begin w_cmd_unknown_next = 1'b1; w_state_next = ST_DISCARD; end
            endcase
        end else if (w_rx_valid && w_rx_dc == DATA_BIT) begin
            unique case (r_state)
                ST_PARAM: begin
                    if (r_param == P_PIXFMT) begin
                        w_pix_fmt_next = w_rx_byte;
                        w_state_next   = ST_DISCARD;
                    end else if (r_param == P_MADCTL) begin
                        w_madctl_next = w_rx_byte;
                        w_state_next  = ST_DISCARD;
                    end else if (r_param_cnt != 2'd3) begin
                        w_param_buf_next = {r_param_buf[15:0], w_rx_byte};
                        w_param_cnt_next = r_param_cnt + 2'd1;
                    end else begin
                        w_state_next = ST_DISCARD;
                        if (w_win_start > w_win_end || w_win_end > w_win_max) begin
                            w_window_err_next = 1'b1;
                        end else if (r_param == P_CASET) begin
                            w_col_start_next = w_win_start;
                            w_col_end_next   = w_win_end;
                        end else begin
                            w_page_start_next = w_win_start;
                            w_page_end_next   = w_win_end;
                        end
                    end
                end
                ST_RAMWR: begin
                    w_hi_valid_next = ~r_hi_valid;
                    if (!r_hi_valid) begin
                        w_hi_next = w_rx_byte;
                    end else if (r_pix_fmt == RGB565) begin
                        w_pix_valid_next = 1'b1;
                        w_pix_x_next     = r_cur_x;
                        w_pix_y_next     = r_cur_y;
                        w_pix_data_next  = {r_hi, w_rx_byte};
                        if (r_cur_x == r_col_end) begin
                            w_cur_x_next = r_col_start;
                            w_cur_y_next = (r_cur_y == r_page_end) ? r_page_start : r_cur_y + 16'd1;
                        end else begin
                            w_cur_x_next = r_cur_x + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;        r_param <= P_PIXFMT;
            r_param_cnt <= 2'd0;       r_param_buf <= 24'd0;
            r_hi <= 8'd0;              r_hi_valid <= 1'b0;
            r_cur_x <= 16'd0;          r_cur_y <= 16'd0;
            r_col_start <= 16'd0;      r_col_end <= X_MAX;
            r_page_start <= 16'd0;     r_page_end <= Y_MAX;
            r_sleeping <= 1'b1;        r_display_on <= 1'b0;
            r_pix_fmt <= RGB666;       r_madctl <= 8'h00;
            r_pix_valid <= 1'b0;       r_pix_x <= 16'd0;
            r_pix_y <= 16'd0;          r_pix_data <= 16'd0;
            r_cmd_unknown <= 1'b0;     r_window_err <= 1'b0;
        end else begin
            r_state <= w_state_next;           r_param <= w_param_next;
            r_param_cnt <= w_param_cnt_next;   r_param_buf <= w_param_buf_next;
            r_hi <= w_hi_next;                 r_hi_valid <= w_hi_valid_next;
            r_cur_x <= w_cur_x_next;           r_cur_y <= w_cur_y_next;
            r_col_start <= w_col_start_next;   r_col_end <= w_col_end_next;
            r_page_start <= w_page_start_next; r_page_end <= w_page_end_next;
            r_sleeping <= w_sleeping_next;     r_display_on <= w_display_on_next;
            r_pix_fmt <= w_pix_fmt_next;       r_madctl <= w_madctl_next;
            r_pix_valid <= w_pix_valid_next;   r_pix_x <= w_pix_x_next;
            r_pix_y <= w_pix_y_next;           r_pix_data <= w_pix_data_next;
            r_cmd_unknown <= w_cmd_unknown_next;
            r_window_err <= w_window_err_next;
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_x       = r_pix_x;
    assign bus.pix_y       = r_pix_y;
    assign bus.pix_data    = r_pix_data;
    assign bus.sleeping    = r_sleeping;
    assign bus.display_on  = r_display_on;
    assign bus.pix_fmt     = r_pix_fmt;
    assign bus.madctl      = r_madctl;
    assign bus.cmd_unknown = r_cmd_unknown;
    assign bus.window_err  = r_window_err;

endmodule

// File: tb/tb_display_cmd_receiver.sv
// Directed bench for display_cmd_receiver on a 4x3 panel: a byte/pixel vector
// table for the raster pass plus hand-written multi-cycle sequences.
module tb_display_cmd_receiver;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_cmd_receiver_if bus();

    display_cmd_receiver #(.DIS_RES_X(4), .DIS_RES_Y(3), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        logic        exp_pix;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int pix_cnt = 0, unk_cnt = 0, unk_cyc = 0, werr_cnt = 0;
    logic [15:0] last_x = 16'd0, last_y = 16'd0, last_data = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pix_valid) begin
            pix_cnt++;
            last_x = bus.pix_x;
            last_y = bus.pix_y;
            last_data = bus.pix_data;
        end
        if (bus.cmd_unknown) begin
            unk_cnt++;
            unk_cyc = cyc;
        end
        if (bus.window_err) werr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic send_byte(input logic is_data, input logic [7:0] b);
        bus.spi_cs_n = 1'b0;
        bus.dc = is_data;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.spi_mosi = b[i];
            repeat (3) @(negedge clk);
            bus.spi_sck = 1'b1;
            if (i == 0) last_rise_cyc = cyc;
            repeat (4) @(negedge clk);
            bus.spi_sck = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    int p0, u0, w0;
    logic [7:0] partial;

    initial begin
        bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs_n = 1'b1;
        bus.dc = 1'b0; bus.dis_reset = 1'b1;

        // Raster pass: PIXFMT 55, window 0..3 x 0..2, then 13 pixels of 0xF800.
        tbl.push_back('{1'b0, 8'h3A, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h55, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b0, 8'h2A, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h03, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b0, 8'h2B, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 16'd0, 16'd0, 16'd0});
        tbl.push_back('{1'b0, 8'h2C, 1'b0, 16'd0, 16'd0, 16'd0});
        for (int i = 0; i < 13; i++) begin
            tbl.push_back('{1'b1, 8'hF8, 1'b0, 16'd0, 16'd0, 16'd0});
            tbl.push_back('{1'b1, 8'h00, 1'b1, 16'(i % 4), 16'((i / 4) % 3), 16'hF800});
        end

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sleeping", 32'(bus.sleeping), 32'd1);
        check("rst_display_on", 32'(bus.display_on), 32'd0);
        check("rst_pix_fmt", 32'(bus.pix_fmt), 32'h66);
        check("rst_madctl", 32'(bus.madctl), 32'h00);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_x", 32'(bus.pix_x), 32'd0);

        cmd(8'h11);
        cmd(8'h29);
        check("wake_sleeping", 32'(bus.sleeping), 32'd0);
        check("wake_display_on", 32'(bus.display_on), 32'd1);
        check("wake_pix_fmt", 32'(bus.pix_fmt), 32'h66);
        check("wake_no_pix", 32'(pix_cnt), 32'd0);
        cmd(8'h36); dat(8'hA5);
        check("madctl", 32'(bus.madctl), 32'hA5);

        for (int v = 0; v < tbl.size(); v++) begin
            p0 = pix_cnt;
            send_byte(tbl[v].dc, tbl[v].data);
            $display("vec %0d: dc=%0d byte=%02h", v, tbl[v].dc, tbl[v].data);
            check($sformatf("v%0d_pix_cnt", v), 32'(pix_cnt - p0), 32'(tbl[v].exp_pix));
            if (tbl[v].exp_pix) begin
                check($sformatf("v%0d_x", v), 32'(last_x), 32'(tbl[v].exp_x));
                check($sformatf("v%0d_y", v), 32'(last_y), 32'(tbl[v].exp_y));
                check($sformatf("v%0d_data", v), 32'(last_data), 32'(tbl[v].exp_data));
            end
        end
        check("raster_total", 32'(pix_cnt), 32'd13);

        // Rejected windows leave 0..3 x 0..2 in place.
        w0 = werr_cnt;
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h02);
        check("werr_start_gt_end", 32'(werr_cnt - w0), 32'd1);
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h04);
        check("werr_end_oob", 32'(werr_cnt - w0), 32'd2);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) begin
            dat(8'h12); dat(8'h34);
            if (i == 3) check("win_row_end_x", 32'(last_x), 32'd3);
        end
        check("win_wrap_x", 32'(last_x), 32'd0);
        check("win_wrap_y", 32'(last_y), 32'd1);
        check("win_data", 32'(last_data), 32'h1234);

        // Valid PASET 1..2 moves the start page; an interrupted CASET changes nothing.
        cmd(8'h2B); dat(8'h00); dat(8'h01); dat(8'h00); dat(8'h02);
        cmd(8'h2A); dat(8'h00); dat(8'h02);
        cmd(8'h2C); dat(8'hAA); dat(8'h55);
        check("paset_x", 32'(last_x), 32'd0);
        check("paset_y", 32'(last_y), 32'd1);
        check("paset_no_err", 32'(werr_cnt - w0), 32'd2);

        // Partial byte on CS_n deselect is discarded.
        cmd(8'h3A); dat(8'h66);
        check("pixfmt_66", 32'(bus.pix_fmt), 32'h66);
        partial = 8'hFF;
        bus.spi_cs_n = 1'b0; bus.dc = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            @(negedge clk); bus.spi_mosi = partial[i];
            repeat (3) @(negedge clk); bus.spi_sck = 1'b1;
            repeat (4) @(negedge clk); bus.spi_sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        cmd(8'h3A); dat(8'h55);
        check("partial_pixfmt", 32'(bus.pix_fmt), 32'h55);

        // Unknown command: single pulse at SYNC+2 clk after the last SCK rise.
        u0 = unk_cnt; p0 = pix_cnt;
        cmd(8'hB1);
        check("unk_latency", 32'(unk_cyc - last_rise_cyc), 32'(SYNC + 2));
        dat(8'h01); dat(8'h02); dat(8'h03);
        check("unk_count", 32'(unk_cnt - u0), 32'd1);
        check("unk_no_pix", 32'(pix_cnt - p0), 32'd0);
        check("unk_pix_fmt", 32'(bus.pix_fmt), 32'h55);

        // RAMWR in RGB666 produces no pixel writes.
        cmd(8'h3A); dat(8'h66);
        p0 = pix_cnt;
        cmd(8'h2C); dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
        check("fmt66_no_pix", 32'(pix_cnt - p0), 32'd0);

        // Panel reset mid-RAMWR drops the dangling high byte and the rest of the stream.
        cmd(8'h3A); dat(8'h55); cmd(8'h11);
        cmd(8'h2C);
        p0 = pix_cnt;
        dat(8'hAB); dat(8'hCD);
        check("pre_disrst_pix", 32'(pix_cnt - p0), 32'd1);
        check("pre_disrst_data", 32'(last_data), 32'hABCD);
        dat(8'h11);
        bus.dis_reset = 1'b0;
        repeat (10) @(negedge clk);
        bus.dis_reset = 1'b1;
        repeat (4) @(negedge clk);
        dat(8'h22); dat(8'h33); dat(8'h44);
        check("disrst_no_pix", 32'(pix_cnt - p0), 32'd1);
        check("disrst_sleeping", 32'(bus.sleeping), 32'd1);
        check("disrst_pix_fmt", 32'(bus.pix_fmt), 32'h66);
        check("disrst_display_on", 32'(bus.display_on), 32'd0);
        check("disrst_madctl", 32'(bus.madctl), 32'h00);
        check("disrst_hold_data", 32'(bus.pix_data), 32'hABCD);

        // Software reset command.
        cmd(8'h11); cmd(8'h29);
        check("pre_swrst_sleeping", 32'(bus.sleeping), 32'd0);
        cmd(8'h01);
        check("swrst_sleeping", 32'(bus.sleeping), 32'd1);
        check("swrst_display_on", 32'(bus.display_on), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_cmd_receiver.md
# display_cmd_receiver

- Display-side model of the ILI9341-style SPI link.
- Deserialises the 4-wire SPI stream (SCK, MOSI, CS_n, DC) driven by `master_spi_controller`/SB_SPI out to the panel pins.
- Decodes command and parameter bytes and turns RAMWR payload into addressed RGB565 pixel writes.
- Used as the panel end in closed-loop benches of `display_controller`, and as the receive front end for a future framebuffer sink.

## Interface
- `DIS_RES_X`, default 240: panel width in pixels; columns 0..DIS_RES_X-1.
- `DIS_RES_Y`, default 320: panel height in pixels; pages 0..DIS_RES_Y-1.
- `SYNC_STAGES`, default 2: synchroniser depth on SCK, MOSI, CS_n, DC, dis_reset.
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `spi_sck` in 1: SPI clock, mode 0; frequency ≤ clk/4.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_cs_n` in 1: chip select, active low.
- `dc` in 1: 0 = command byte, 1 = data byte; sampled on the 8th SCK rise of each byte.
- `dis_reset` in 1: panel hardware reset, active low.
- `pix_valid` out 1: one-cycle pulse; a pixel write is presented.
- `pix_x` out 16: column of the pixel write.
- `pix_y` out 16: page of the pixel write.
- `pix_data` out 16: RGB565 value of the pixel write.
- `sleeping` out 1: 1 until SLEEP_OUT.
- `display_on` out 1: set by DISPLAY_ON.
- `pix_fmt` out 8: last PIXFMT parameter.
- `madctl` out 8: last MADCTL parameter.
- `cmd_unknown` out 1: one-cycle pulse on an unsupported command byte.
- `window_err` out 1: one-cycle pulse when a CASET/PASET window is rejected.

## Operation
- **Byte assembly**
  - Bits shift in on each synchronised SCK rising edge while CS_n is low.
  - CS_n high clears the bit counter and discards any partial byte.
  - The 8th bit emits an internal `rx_valid`, `rx_byte`, `rx_dc`.
- **Register reset** (sync `reset`, dis_reset low, or SW_RESET 0x01) sets:
  - sleeping=1, display_on=0, pix_fmt=0x66, madctl=0x00;
  - column window 0..DIS_RES_X-1, page window 0..DIS_RES_Y-1;
  - FSM to IDLE.
  - `reset` also clears all outputs to 0, except sleeping=1 and pix_fmt=0x66.
- **FSM states**: IDLE, PARAM, RAMWR, DISCARD.
  - Any command byte (dc=0) leaves the current state immediately. Partially received CASET/PASET parameters are dropped and the window is unchanged.
  - 0x11 SLEEP_OUT: sleeping=0. Next state IDLE.
  - 0x29 DISPLAY_ON: display_on=1. Next state IDLE.
  - 0x3A PIXFMT: PARAM, expecting 1 byte, which goes to pix_fmt.
  - 0x36 MADCTL: PARAM, expecting 1 byte, which goes to madctl.
  - 0x2A CASET / 0x2B PASET: PARAM, expecting 4 bytes (start[15:8], start[7:0], end[15:8], end[7:0]).
    - Applied on the 4th byte only.
    - Rejected with a window_err pulse if start>end or end≥DIS_RES (X or Y).
  - After the expected parameter count, the FSM goes to DISCARD until the next command.
  - 0x2C RAMWR: cursor set to (col_start, page_start), byte phase cleared, state RAMWR.
  - Any other command: cmd_unknown pulse, then DISCARD.
- **RAMWR**
  - Data bytes pair up as high byte then low byte.
  - On the low byte, if pix_fmt==0x55, the FSM pulses pix_valid with the current cursor and {hi,lo}. Otherwise the pair is silently discarded.
  - Cursor advance: x==col_end → x=col_start and y++. y==page_end with x==col_end → wrap to (col_start, page_start).
  - A dangling high byte is dropped when a command arrives.
- A data byte received in IDLE is ignored.
- madctl is stored only; it has no effect on addressing.

## Timing
- Each synchronised SCK rise is detected one cycle after leaving the synchroniser.
- `rx_valid` fires SYNC_STAGES+1 clk after the 8th SCK rise at the pin.
- Register updates and pix_valid/cmd_unknown/window_err appear registered, one clk after `rx_valid`. Total latency is SYNC_STAGES+2 clk from the last SCK rise of the byte.
- pix_x/pix_y/pix_data hold until the next pix_valid.
- dis_reset low takes effect SYNC_STAGES+1 clk after the pin falls. It holds register reset while low, and the in-flight byte is discarded.
- `reset` asserted mid-byte or mid-RAMWR aborts in the same cycle. Outputs take reset values on the next edge.
- A byte completion and dis_reset in the same cycle: reset wins.

## Structure
- Command codes, COMMAND_BIT/DATA_BIT and RGB565 (0x55) live in the shared display command header already used by `display_controller`. No local literals.
- Sub-module `spi_byte_receiver`: synchronisers, edge detection and bit counter; outputs rx_valid/rx_byte/rx_dc.
- Decoder FSM and cursor logic live in `display_cmd_receiver`.

## Test plan
- Reset, then SLEEP_OUT, DISPLAY_ON → sleeping=0, display_on=1, pix_fmt=0x66, no pix_valid.
- PIXFMT 0x55; CASET 0,0,0,3; PASET 0,0,0,2; RAMWR plus 24 bytes F8,00 repeated (DIS_RES_X=4, DIS_RES_Y=3) → 12 pix_valid pulses with data 0xF800, (x,y) raster order (0,0)..(3,2).
- Continue with 2 more bytes → 13th pixel wraps to (0,0).
- CASET 0,5,0,2 → window_err pulse; a following RAMWR starts at x=0 with window 0..3.
- CS_n raised after 5 bits of a command, then a full PIXFMT with 0x55 → partial byte discarded, pix_fmt=0x55.
- Command 0xB1 followed by 3 data bytes → one cmd_unknown pulse, state unchanged.
- RAMWR with pix_fmt=0x66 → no pix_valid.
- dis_reset pulsed low mid-RAMWR → sleeping=1, pix_fmt=0x66, no further pix_valid.
